// File: rtl/zdraw_scheduler_if.sv
// Request/core bus of the ZDrawCore scheduler.
// slave  : scheduler side (takes requests and core done, drives the core and status)
// master : environment side (requesters, ZDrawCore, status consumers)
// Signals: en, iReq[3:0], iReq_Data[127:0], iCore_Done,
//          oCore_En, oCore_Cmd[3:0], oCore_Data[31:0],
//          oBusy, oInit_Done, oServiced[3:0], oTimeout_Err
interface zdraw_scheduler_if;
  localparam int unsigned NSRC = 4;
  localparam int unsigned DW   = 32;
  localparam int unsigned CW   = 4;

  logic                 en;
  logic [NSRC-1:0]      iReq;
  logic [NSRC*DW-1:0]   iReq_Data;
  logic                 iCore_Done;
  logic                 oCore_En;
  logic [CW-1:0]        oCore_Cmd;
  logic [DW-1:0]        oCore_Data;
  logic                 oBusy;
  logic                 oInit_Done;
  logic [NSRC-1:0]      oServiced;
  logic                 oTimeout_Err;

  modport slave (
    input  en, iReq, iReq_Data, iCore_Done,
    output oCore_En, oCore_Cmd, oCore_Data, oBusy, oInit_Done, oServiced, oTimeout_Err
  );

  modport master (
    output en, iReq, iReq_Data, iCore_Done,
    input  oCore_En, oCore_Cmd, oCore_Data, oBusy, oInit_Done, oServiced, oTimeout_Err
  );
endinterface

// File: rtl/zdraw_scheduler.sv
// Shares ZDrawCore between four draw requesters (RTC, new pulse counter,
// mode icon, accumulated counter). After reset it issues a fixed init
// sequence, then services latched requests round-robin, one command at a
// time, over the core's en/done handshake with a per-command timeout.
// Ports: clk, rst (sync, active high), bus (zdraw_scheduler_if.slave).
module zdraw_scheduler #(
  parameter logic [3:0]  CMD_SRC0  = 4'd2,
  parameter logic [3:0]  CMD_SRC1  = 4'd5,
  parameter logic [3:0]  CMD_SRC2  = 4'd7,
  parameter logic [3:0]  CMD_SRC3  = 4'd8,
  parameter logic [3:0]  INIT_CMD0 = 4'd0,
  parameter logic [3:0]  INIT_CMD1 = 4'd1,
  parameter logic [3:0]  INIT_CMD2 = 4'd4,
  parameter int unsigned TIMEOUT   = 2000000
) (
  input logic              clk,
  input logic              rst,
  zdraw_scheduler_if.slave bus
);

  localparam int unsigned NSRC  = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned CW    = 4;
  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_GAP} state_t;

  state_t                      state, state_n;
  logic [NSRC-1:0]             pending, pending_n;
  logic [NSRC-1:0][DW-1:0]     lat_data;
  logic [1:0]                  rr, rr_n;
  logic [1:0]                  init_idx, init_idx_n;
  logic [1:0]                  cur, cur_n;
  logic [CNT_W-1:0]            cnt, cnt_n;
  logic                        core_en, core_en_n;
  logic [CW-1:0]               cmd, cmd_n;
  logic [DW-1:0]               data, data_n;
  logic                        busy_n, busy;
  logic                        init_done, init_done_n;
  logic [NSRC-1:0]             serviced, serviced_n;
  logic                        terr, terr_n;

  logic                        found;
  logic [1:0]                  win;
  logic [1:0]                  cand;
  logic                        tmo;

  function automatic logic [CW-1:0] src_cmd(input logic [1:0] k);
    case (k)
      2'd0:    src_cmd = CMD_SRC0;
      2'd1:    src_cmd = CMD_SRC1;
      2'd2:    src_cmd = CMD_SRC2;
      default: src_cmd = CMD_SRC3;
    endcase
  endfunction

  function automatic logic [CW-1:0] init_cmd(input logic [1:0] k);
    case (k)
      2'd0:    init_cmd = INIT_CMD0;
      2'd1:    init_cmd = INIT_CMD1;
      default: init_cmd = INIT_CMD2;
    endcase
  endfunction

  // State and output registers; request data latched independently of state
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_INIT;
      pending   <= '0;
      lat_data  <= '0;
      rr        <= '0;
      init_idx  <= '0;
      cur       <= '0;
      cnt       <= '0;
      core_en   <= 1'b0;
      cmd       <= '0;
      data      <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      serviced  <= '0;
      terr      <= 1'b0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      rr        <= rr_n;
      init_idx  <= init_idx_n;
      cur       <= cur_n;
      cnt       <= cnt_n;
      core_en   <= core_en_n;
      cmd       <= cmd_n;
      data      <= data_n;
      busy      <= busy_n;
      init_done <= init_done_n;
      serviced  <= serviced_n;
      terr      <= terr_n;
      for (int k = 0; k < NSRC; k++) begin
        if (bus.iReq[k]) lat_data[k] <= bus.iReq_Data[DW*k +: DW];
      end
    end
  end

  // Next-state, grant and registered-output values
  always_comb begin
    state_n     = state;
    pending_n   = pending;
    rr_n        = rr;
    init_idx_n  = init_idx;
    cur_n       = cur;
    cnt_n       = cnt;
    core_en_n   = core_en;
    cmd_n       = cmd;
    data_n      = data;
    init_done_n = init_done;
    serviced_n  = '0;
    terr_n      = terr;
    found       = 1'b0;
    win         = '0;
    cand        = '0;
    // Counter reaching TIMEOUT-1 on this WAIT cycle's increment
    tmo         = (cnt == CNT_W'(TIMEOUT - 2));

    // Round-robin search upward from rr, wrapping 3->0
    for (int i = 0; i < NSRC; i++) begin
      cand = rr + 2'(i);
      if (!found && pending[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end

    case (state)
      S_INIT: begin
        if (bus.en) begin
          cmd_n     = init_cmd(init_idx);
          data_n    = '0;
          core_en_n = 1'b1;
          cnt_n     = '0;
          state_n   = S_WAIT;
        end
      end
      S_IDLE: begin
        if (bus.en && found) begin
          cur_n          = win;
          cmd_n          = src_cmd(win);
          data_n         = lat_data[win];
          pending_n[win] = 1'b0;
          rr_n           = win + 2'd1;
          core_en_n      = 1'b1;
          cnt_n          = '0;
          state_n        = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_n = S_WAIT;
      end
      S_WAIT: begin
        if (bus.iCore_Done || tmo) begin
          core_en_n = 1'b0;
          state_n   = S_GAP;
          if (!bus.iCore_Done) terr_n = 1'b1;
          if (init_done) begin
            serviced_n[cur] = 1'b1;
          end else begin
            init_idx_n = init_idx + 2'd1;
            if (init_idx == 2'd2) init_done_n = 1'b1;
          end
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        state_n = (init_idx < 2'd3) ? S_INIT : S_IDLE;
      end
      default: begin
        state_n = S_INIT;
      end
    endcase

    // A same-cycle request re-arms the source even if it was just granted
    pending_n = pending_n | bus.iReq;
    busy_n    = (state_n == S_ISSUE) || (state_n == S_WAIT) || (state_n == S_GAP);
  end

  assign bus.oCore_En     = core_en;
  assign bus.oCore_Cmd    = cmd;
  assign bus.oCore_Data   = data;
  assign bus.oBusy        = busy;
  assign bus.oInit_Done   = init_done;
  assign bus.oServiced    = serviced;
  assign bus.oTimeout_Err = terr;

endmodule
